pc_sequencer: RTL and testbench

- Fetch-side controller that drives the PC register's next-PC select.
- Arbitrates between sequential fetch (PC+2), J-type jumps/calls resolved in ID, I-type branches resolved in EX, and returns.
- Owns a circular return-address stack (RAS) and produces pipeline flush/stall controls for IF/ID and ID/EX.
- Sits between the decode/hazard logic and the PC register.

---
 rtl/pc_sequencer_if.sv | 44 ++++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer handshake bundle: decode/hazard requests in, PC-select controls out.
// The master drives the requests; the slave is the sequencer itself.
interface pc_sequencer_if;
  logic        stall_i;
  logic        jump_i;
  logic        call_i;
  logic        return_i;
  logic [15:0] jump_target_i;
  logic        branch_taken_i;
  logic [15:0] branch_target_i;
  logic [15:0] pc_id_i;
  logic [1:0]  PCsrc;
  logic [15:0] j_target_o;
  logic [15:0] i_target_o;
  logic [15:0] ret_addr_o;
  logic        pc_write_en;
  logic        flush_ifid;
  logic        flush_idex;
  logic        ras_overflow;
  logic        ras_underflow;
  logic [1:0]  state_o;

  modport master (
    output stall_i, jump_i, call_i, return_i,
    output jump_target_i, branch_taken_i,
    output branch_target_i, pc_id_i,
    input  PCsrc, j_target_o, i_target_o,
    input  ret_addr_o, pc_write_en,
    input  flush_ifid, flush_idex,
    input  ras_overflow, ras_underflow,
    input  state_o
  );

  modport slave (
    input  stall_i, jump_i, call_i, return_i,
    input  jump_target_i, branch_taken_i,
    input  branch_target_i, pc_id_i,
    output PCsrc, j_target_o, i_target_o,
    output ret_addr_o, pc_write_en,
    output flush_ifid, flush_idex,
    output ras_overflow, ras_underflow,
    output state_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC select, flush/stall control and circular return-address stack.
// Branch in EX outranks stall, which outranks jump/return from ID.
module pc_sequencer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  sq
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    REDIR = 2'b10
  } state_e;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_e             state_q, state_d;
  logic [15:0]        ras_q [DEPTH];
  logic [15:0]        ras_d [DEPTH];
  logic [PTR_W-1:0]   top_q, top_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [1:0]         pcsrc;
  logic               we, f_ifid, f_idex;
  logic               push, pop;
  logic [15:0]        push_val;

  assign push_val = sq.pc_id_i + 16'd2;

  always_comb begin
    pcsrc   = 2'b00;
    we      = 1'b1;
    f_ifid  = 1'b0;
    f_idex  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    state_d = RUN;
    if (reset) begin
      we      = 1'b0;
      f_ifid  = 1'b1;
      f_idex  = 1'b1;
      state_d = BOOT;
    end else if (state_q == BOOT) begin
      we      = 1'b0;
      f_ifid  = 1'b1;
      f_idex  = 1'b1;
    end else if (sq.branch_taken_i) begin
      pcsrc   = 2'b10;
      f_ifid  = 1'b1;
      f_idex  = 1'b1;
      state_d = REDIR;
    end else if (sq.stall_i) begin
      we      = 1'b0;
      f_idex  = 1'b1;
    end else if (state_q == RUN && sq.jump_i) begin
      pcsrc   = 2'b01;
      f_ifid  = 1'b1;
      push    = sq.call_i;
    end else if (state_q == RUN && sq.return_i) begin
      pcsrc   = 2'b11;
      f_ifid  = 1'b1;
      pop     = 1'b1;
    end
  end

  // Full-stack push overwrites the oldest entry; empty pop leaves the stack alone.
  always_comb begin
    ras_d = ras_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push) begin
      top_d        = top_q + 1'b1;
      ras_d[top_d] = push_val;
      if (cnt_q == FULL) ovf_d = 1'b1;
      else               cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
      end else begin
        top_d = top_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      top_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ras_q   <= ras_d;
    end
  end

  assign sq.PCsrc         = pcsrc;
  assign sq.pc_write_en   = we;
  assign sq.flush_ifid    = f_ifid;
  assign sq.flush_idex    = f_idex;
  assign sq.j_target_o    = sq.jump_target_i;
  assign sq.i_target_o    = sq.branch_target_i;
  assign sq.ret_addr_o    = (cnt_q == '0) ? 16'h0000 : ras_q[top_q];
  assign sq.ras_overflow  = ovf_q;
  assign sq.ras_underflow = unf_q;
  assign sq.state_o       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic
// against a queue-based behavioural model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .sq    (bus)
  );

  int errs   = 0;
  int checks = 0;

  int          m_mode;
  logic [15:0] m_ras [$];
  bit          m_ovf;
  bit          m_unf;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    int          e_src;
    bit          e_we, e_fi, e_fx;
    logic [15:0] e_ret;
    #1;
    e_ret = (m_ras.size() > 0) ? m_ras[$] : 16'h0000;
    e_src = 0; e_we = 1; e_fi = 0; e_fx = 0;
    if (reset) begin
      e_we = 0; e_fi = 1; e_fx = 1;
    end else if (m_mode == 0) begin
      e_we = 0; e_fi = 1; e_fx = 1;
    end else if (bus.branch_taken_i) begin
      e_src = 2; e_fi = 1; e_fx = 1;
    end else if (bus.stall_i) begin
      e_we = 0; e_fx = 1;
    end else if (m_mode == 1 && bus.jump_i) begin
      e_src = 1; e_fi = 1;
    end else if (m_mode == 1 && bus.return_i) begin
      e_src = 3; e_fi = 1;
    end
    chk("state", 32'(bus.state_o), 32'(m_mode));
    chk("pcsrc", 32'(bus.PCsrc), 32'(e_src));
    chk("pc_we", 32'(bus.pc_write_en), 32'(e_we));
    chk("fl_ifid", 32'(bus.flush_ifid), 32'(e_fi));
    chk("fl_idex", 32'(bus.flush_idex), 32'(e_fx));
    chk("ret_addr", 32'(bus.ret_addr_o), 32'(e_ret));
    chk("ovf", 32'(bus.ras_overflow), 32'(m_ovf));
    chk("unf", 32'(bus.ras_underflow), 32'(m_unf));
    chk("j_tgt", 32'(bus.j_target_o), 32'(bus.jump_target_i));
    chk("i_tgt", 32'(bus.i_target_o), 32'(bus.branch_target_i));
    if (reset) begin
      m_mode = 0; m_ras.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (bus.branch_taken_i) begin
      m_mode = 2;
    end else begin
      if (!bus.stall_i && m_mode == 1) begin
        if (bus.jump_i) begin
          if (bus.call_i) begin
            if (m_ras.size() == 8) begin
              void'(m_ras.pop_front());
              m_ovf = 1;
            end
            m_ras.push_back(bus.pc_id_i + 16'd2);
          end
        end else if (bus.return_i) begin
          if (m_ras.size() == 0) m_unf = 1;
          else void'(m_ras.pop_back());
        end
      end
      m_mode = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(bit br, bit st, bit j, bit c, bit r,
                     logic [15:0] jt, logic [15:0] bt, logic [15:0] pc);
    bus.branch_taken_i  = br;
    bus.stall_i         = st;
    bus.jump_i          = j;
    bus.call_i          = c;
    bus.return_i        = r;
    bus.jump_target_i   = jt;
    bus.branch_target_i = bt;
    bus.pc_id_i         = pc;
    cyc();
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    reset = 1'b1;
    m_mode = 0; m_ovf = 0; m_unf = 0;
    bus.branch_taken_i = 0; bus.stall_i = 0;
    bus.jump_i = 0; bus.call_i = 0; bus.return_i = 0;
    bus.jump_target_i = 0; bus.branch_target_i = 0;
    bus.pc_id_i = 0;
    @(negedge clk);
    idle();
    idle();
    reset = 1'b0;
    idle();
    idle();
    idle();

    // call then return
    drv(0, 0, 1, 1, 0, 16'h0100, 16'h0, 16'h0010);
    idle();
    bus.return_i = 1'b1;
    #1 chk("ret_0012", 32'(bus.ret_addr_o), 32'h0012);
    drv(0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
    idle();

    // branch beats jump, call and stall
    drv(1, 1, 1, 1, 0, 16'h0200, 16'h0040, 16'h0020);
    drv(0, 0, 1, 0, 0, 16'h0300, 16'h0, 16'h0);
    idle();

    // stall holding a jump
    drv(0, 1, 1, 0, 0, 16'h0400, 16'h0, 16'h0030);
    drv(0, 1, 1, 0, 0, 16'h0400, 16'h0, 16'h0030);
    drv(0, 0, 1, 0, 0, 16'h0400, 16'h0, 16'h0030);

    // overflow then drain into underflow
    for (int i = 0; i < 9; i++)
      drv(0, 0, 1, 1, 0, 16'h0500, 16'h0, 16'(2 * i));
    for (int i = 0; i < 9; i++)
      drv(0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
    chk("underflow", 32'(bus.ras_underflow), 32'h1);

    // wrap at top of address space, then reset during a stall
    drv(0, 0, 1, 1, 0, 16'h0600, 16'h0, 16'hFFFE);
    bus.return_i = 1'b1;
    #1 chk("ret_wrap", 32'(bus.ret_addr_o), 32'h0000);
    drv(0, 0, 1, 1, 0, 16'h0600, 16'h0, 16'h0050);
    reset = 1'b1;
    drv(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    reset = 1'b0;
    idle();
    drv(0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom % 250) == 0;
      drv(($urandom % 7) == 0, ($urandom % 6) == 0,
          ($urandom % 3) == 0, ($urandom % 2) == 0,
          ($urandom % 3) == 0, 16'($urandom), 16'($urandom),
          (($urandom % 10) == 0) ? 16'hFFFE : 16'($urandom));
    end
    reset = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
